updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised up/down modulo counter, the successor to the team's fixed 4-bit up counter. Adds configurable width and modulus, direction control, count enable, synchronous parallel load, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. It is used for timers, event tallies and decade/BCD-style prescalers.

## Interface
- WIDTH, 4: counter width in bits; must be at least 2.
- MAX_VAL, (1<<WIDTH)-1: highest count value; the count range is 0..MAX_VAL; must be at least 1 and fit in WIDTH bits.
- RESET_VAL, 0: value loaded on reset; must be at most MAX_VAL.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable; one step per clk while high.
- dir  input  1  1 = count up, 0 = count down; sampled only on counting cycles.
- sat  input  1  1 = saturate at the boundary, 0 = wrap modulo MAX_VAL+1.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value for load.
- clr_ovf  input  1  synchronous clear of ovf.
- counter  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse (registered, one cycle per boundary event).
- ovf  output  1  sticky boundary-event flag (registered).

## Operation
- **Reset.** While reset=0, asynchronously: counter=RESET_VAL, tc=0, ovf=0. Release is synchronous to the next clk edge.
- **Per-edge priority.** load, then en, then hold.
- **Load (load=1).**
  - counter takes load_val; a load_val above MAX_VAL is clamped to MAX_VAL.
  - tc=0. ovf is not affected by the load itself.
  - en is ignored that cycle.
- **Count, up (en=1, load=0, dir=1).**
  - If counter<MAX_VAL: counter+1, tc=0.
  - If counter==MAX_VAL, a boundary event occurs:
    - wrap mode (sat=0): counter becomes 0.
    - saturate mode (sat=1): counter holds at MAX_VAL.
    - In both modes, tc=1 for one cycle.
- **Count, down (en=1, load=0, dir=0).**
  - If counter>0: counter-1, tc=0.
  - If counter==0, a boundary event occurs:
    - wrap mode: counter becomes MAX_VAL.
    - saturate mode: counter holds at 0.
    - In both modes, tc=1.
- **Hold (en=0, load=0).** counter holds, tc=0.
- **Saturated and enabled.** If counting stays enabled while saturated at the boundary, tc fires on every such cycle. Every attempted step past the boundary is an event.
- **ovf.**
  - Set on any boundary event.
  - Cleared by clr_ovf=1.
  - If clr_ovf=1 and a boundary event occur on the same edge, set wins and ovf=1.
- **Arithmetic.** Use WIDTH+1 bits internally. The counter never holds a value above MAX_VAL, including when MAX_VAL < 2^WIDTH-1.
- **Control changes.** dir and sat changes take effect on the next counting edge. No internal state depends on their previous values.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Latency is one clk: a change on en, load or dir is reflected on counter after the next rising edge.
- tc is high in exactly the cycle in which counter shows the post-event value (wrapped or held).
- Reset asserted mid-count forces the reset values immediately, without waiting for clk. The first post-release edge with en=1 counts from RESET_VAL.
- Back-to-back loads are legal on every cycle.
- Any level change on en is honoured on the very next edge.

## Test plan
Directed scenarios use WIDTH=4, MAX_VAL=9, RESET_VAL=0 unless noted.
- **Reset, then up-wrap.** Reset low, release, then en=1, dir=1, sat=0 for 12 cycles → counter 1..9,0,1,2; tc=1 only in the cycle counter=0; ovf=1 afterwards.
- **Down-saturate.** Load 2 with sat=1, dir=0, en=1 for 4 cycles → counter 1,0,0,0; tc=1 in the last two cycles; ovf=1.
- **Load clamp and priority.** load=1, load_val=13, en=1, dir=1 → counter=9 and tc=0. Next cycle with en=1, sat=0 → counter=0, tc=1.
- **ovf clear collision.** With ovf=1 and counter=9, assert clr_ovf=1 together with an up step → ovf stays 1. Next cycle, clr_ovf=1 with en=0 → ovf=0.
- **Asynchronous reset mid-count.** With counter=6, drive reset low between edges → counter=0, tc=0, ovf=0 before the next edge. After release, the first enabled edge gives counter=1.
- **Full-range wrap.** With WIDTH=4, MAX_VAL=15, RESET_VAL=5: 11 up steps → counter reaches 0 with tc=1. Then dir=0 for one step → counter=15, tc=1.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with load, wrap/saturate modes,
// a terminal-count pulse and a sticky overflow flag.
module updown_mod_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_VAL   = (1 << WIDTH) - 1,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);

    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH:0]   step_ext;
    logic             past_edge;
    logic             boundary;
    logic [WIDTH-1:0] next_counter;

    assign count_ext = {1'b0, counter};
    assign load_ext  = {1'b0, load_val};

    // The extra bit exposes both the step past MAX_VAL and the borrow below 0.
    always_comb begin
        if (dir) begin
            step_ext  = count_ext + (WIDTH + 1)'(1);
            past_edge = (step_ext > MAX_EXT);
        end else begin
            step_ext  = count_ext - (WIDTH + 1)'(1);
            past_edge = step_ext[WIDTH];
        end
    end

    assign boundary = !load && en && past_edge;

    always_comb begin
        next_counter = counter;
        if (load) begin
            next_counter = (load_ext > MAX_EXT) ? MAX_CNT : load_val;
        end else if (en) begin
            if (!past_edge)
                next_counter = step_ext[WIDTH-1:0];
            else if (sat)
                next_counter = dir ? MAX_CNT : '0;
            else
                next_counter = dir ? '0 : MAX_CNT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter <= RST_CNT;
            tc      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            counter <= next_counter;
            tc      <= boundary;
            ovf     <= boundary || (ovf && !clr_ovf);
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter: a MAX_VAL=9 instance driven from a
// vector table and a random run, and a MAX_VAL=15/RESET_VAL=5 instance for full-range wrap.
module tb_updown_mod_counter;

    typedef struct {
        logic       load;
        logic [3:0] load_val;
        logic       en;
        logic       dir;
        logic       sat;
        logic       clr_ovf;
        logic [3:0] exp_cnt;
        logic       exp_tc;
        logic       exp_ovf;
    } vec_t;

    typedef struct {
        string      name;
        logic       which;
        logic [3:0] cnt;
        logic       tc;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0, dir = 1'b0, sat = 1'b0, load = 1'b0, clr_ovf = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] counter, counter_full;
    logic       tc, tc_full, ovf, ovf_full;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_cnt;
    logic m_tc, m_ovf;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0)) dut (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .sat(sat), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf),
        .counter(counter), .tc(tc), .ovf(ovf)
    );

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(15), .RESET_VAL(5)) dut_full (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .sat(sat), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf),
        .counter(counter_full), .tc(tc_full), .ovf(ovf_full)
    );

    task automatic add_vec(input logic ld, input logic [3:0] lv, input logic e,
                           input logic d, input logic s, input logic c,
                           input logic [3:0] xc, input logic xt, input logic xo);
        vec_t v;
        v.load = ld; v.load_val = lv; v.en = e; v.dir = d; v.sat = s; v.clr_ovf = c;
        v.exp_cnt = xc; v.exp_tc = xt; v.exp_ovf = xo;
        vecs.push_back(v);
    endtask

    task automatic compare(input string name, input logic [3:0] cnt, input logic t,
                           input logic o, input logic [3:0] xc, input logic xt,
                           input logic xo);
        n_tests++;
        if (cnt !== xc || t !== xt || o !== xo) begin
            n_fail++;
            $display("[TB] FAIL %s: got counter=%0d tc=%b ovf=%b, expected counter=%0d tc=%b ovf=%b",
                     name, cnt, t, o, xc, xt, xo);
        end
    endtask

    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL scoreboard: got empty queue, expected a pending entry");
            return;
        end
        e = sb.pop_front();
        if (e.which)
            compare(e.name, counter_full, tc_full, ovf_full, e.cnt, e.tc, e.ovf);
        else
            compare(e.name, counter, tc, ovf, e.cnt, e.tc, e.ovf);
    endtask

    task automatic apply_stimulus(input vec_t v, input string name, input logic which);
        exp_t e;
        load = v.load; load_val = v.load_val; en = v.en;
        dir = v.dir; sat = v.sat; clr_ovf = v.clr_ovf;
        e.name = name; e.which = which;
        e.cnt = v.exp_cnt; e.tc = v.exp_tc; e.ovf = v.exp_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic model_step(input vec_t v, output vec_t r);
        r = v;
        m_tc = 1'b0;
        m_ovf = m_ovf && !v.clr_ovf;
        if (v.load) begin
            m_cnt = (int'(v.load_val) > 9) ? 9 : int'(v.load_val);
        end else if (v.en) begin
            if (v.dir && m_cnt == 9) begin
                m_tc = 1'b1; m_ovf = 1'b1;
                m_cnt = v.sat ? 9 : 0;
            end else if (!v.dir && m_cnt == 0) begin
                m_tc = 1'b1; m_ovf = 1'b1;
                m_cnt = v.sat ? 0 : 9;
            end else begin
                m_cnt = v.dir ? m_cnt + 1 : m_cnt - 1;
            end
        end
        r.exp_cnt = 4'(m_cnt); r.exp_tc = m_tc; r.exp_ovf = m_ovf;
    endtask

    initial begin
        vec_t v, r;

        // up-wrap from reset
        for (int i = 1; i <= 9; i++) add_vec(0, 0, 1, 1, 0, 0, 4'(i), 0, 0);
        add_vec(0, 0, 1, 1, 0, 0, 0, 1, 1);
        add_vec(0, 0, 1, 1, 0, 0, 1, 0, 1);
        add_vec(0, 0, 1, 1, 0, 0, 2, 0, 1);
        add_vec(0, 0, 0, 1, 0, 1, 2, 0, 0);
        add_vec(0, 0, 0, 0, 1, 0, 2, 0, 0);
        // down-saturate
        add_vec(1, 2, 0, 0, 1, 0, 2, 0, 0);
        add_vec(0, 0, 1, 0, 1, 0, 1, 0, 0);
        add_vec(0, 0, 1, 0, 1, 0, 0, 0, 0);
        add_vec(0, 0, 1, 0, 1, 0, 0, 1, 1);
        add_vec(0, 0, 1, 0, 1, 0, 0, 1, 1);
        // load clamp and priority over en
        add_vec(1, 13, 1, 1, 0, 0, 9, 0, 1);
        add_vec(0, 0, 1, 1, 0, 0, 0, 1, 1);
        // clr_ovf colliding with an event, then a plain clear
        add_vec(1, 9, 0, 1, 0, 0, 9, 0, 1);
        add_vec(0, 0, 1, 1, 0, 1, 0, 1, 1);
        add_vec(0, 0, 0, 1, 0, 1, 0, 0, 0);
        // up-saturate, load at boundary, down-wrap, back-to-back loads
        add_vec(1, 9, 0, 1, 1, 0, 9, 0, 0);
        add_vec(0, 0, 1, 1, 1, 0, 9, 1, 1);
        add_vec(1, 15, 0, 0, 0, 0, 9, 0, 1);
        add_vec(1, 0, 0, 0, 0, 0, 0, 0, 1);
        add_vec(0, 0, 1, 0, 0, 1, 9, 1, 1);
        add_vec(0, 0, 1, 0, 0, 0, 8, 0, 1);
        add_vec(1, 3, 1, 0, 0, 0, 3, 0, 1);
        add_vec(1, 7, 1, 1, 0, 0, 7, 0, 1);
        add_vec(1, 10, 0, 0, 0, 0, 9, 0, 1);

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare("reset_state", counter, tc, ovf, 0, 0, 0);
        compare("reset_state_full", counter_full, tc_full, ovf_full, 5, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) apply_stimulus(vecs[i], $sformatf("vec%0d", i), 1'b0);

        // asynchronous reset between edges
        add_vec(1, 6, 0, 1, 0, 0, 6, 0, 1);
        apply_stimulus(vecs[vecs.size() - 1], "async_preload", 1'b0);
        #2;
        reset = 1'b0;
        #1;
        compare("async_reset", counter, tc, ovf, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        add_vec(0, 0, 1, 1, 0, 0, 1, 0, 0);
        apply_stimulus(vecs[vecs.size() - 1], "post_release_step", 1'b0);

        // random run against the reference model
        m_cnt = 1; m_tc = 1'b0; m_ovf = 1'b0;
        for (int i = 0; i < 80; i++) begin
            v.load     = ($urandom_range(0, 7) == 0);
            v.load_val = 4'($urandom_range(0, 15));
            v.en       = ($urandom_range(0, 3) != 0);
            v.dir      = 1'($urandom_range(0, 1));
            v.sat      = 1'($urandom_range(0, 1));
            v.clr_ovf  = ($urandom_range(0, 5) == 0);
            model_step(v, r);
            apply_stimulus(r, $sformatf("rand%0d", i), 1'b0);
        end

        // full-range instance: 5 -> 15 -> 0 wrap, then down-wrap to 15
        @(negedge clk);
        reset = 1'b0;
        #1;
        compare("reset_full", counter_full, tc_full, ovf_full, 5, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            v.load = 0; v.load_val = 0; v.en = 1; v.dir = 1; v.sat = 0; v.clr_ovf = 0;
            v.exp_cnt = 4'((5 + i) % 16);
            v.exp_tc  = (i == 11);
            v.exp_ovf = (i == 11);
            apply_stimulus(v, $sformatf("full_up%0d", i), 1'b1);
        end
        v.dir = 0; v.exp_cnt = 15; v.exp_tc = 1; v.exp_ovf = 1;
        apply_stimulus(v, "full_down_wrap", 1'b1);

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no completion, expected finish before 200000");
        $fatal(1, "[TB] timeout");
    end

endmodule
